// File: rtl/mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_ctrl_if
// Bundles every signal between the memory controller and its neighbours:
//   IF client   : if_rw, if_addr, if_cancel -> if_data, if_status
//   MEM client  : mem_req, mem_we, mem_len, mem_addr, mem_wdata
//                 -> mem_rdata, mem_status
//   I-cache fill: icache_we, icache_addr, icache_data (controller drives)
//   RAM bus     : ram_a, ram_wr, ram_dout (controller drives), ram_din
// Modport slave is the controller's view; master is the view of the
// pipeline/RAM side that surrounds it.
// -----------------------------------------------------------------------------
interface mem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_rw;
  logic [ADDR_W-1:0] if_addr;
  logic              if_cancel;
  logic [DATA_W-1:0] if_data;
  logic [1:0]        if_status;

  logic              mem_req;
  logic              mem_we;
  logic [2:0]        mem_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        mem_status;

  logic              icache_we;
  logic [ADDR_W-1:0] icache_addr;
  logic [DATA_W-1:0] icache_data;

  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;

  modport slave (
    input  if_rw, if_addr, if_cancel,
    output if_data, if_status,
    input  mem_req, mem_we, mem_len, mem_addr, mem_wdata,
    output mem_rdata, mem_status,
    output icache_we, icache_addr, icache_data,
    output ram_a, ram_wr, ram_dout,
    input  ram_din
  );

  modport master (
    output if_rw, if_addr, if_cancel,
    input  if_data, if_status,
    output mem_req, mem_we, mem_len, mem_addr, mem_wdata,
    input  mem_rdata, mem_status,
    input  icache_we, icache_addr, icache_data,
    input  ram_a, ram_wr, ram_dout,
    output ram_din
  );
endinterface

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// Memory-side responder for the IF fetch port and the MEM load/store port.
// Each access is serialised into byte transactions on a single-port RAM whose
// read data (ram_din) arrives one cycle after the address. Words are
// assembled/split little-endian; loads of 1 or 2 bytes are zero-extended.
// MEM requests win over IF requests when both are pending in IDLE.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - mem_ctrl_if.slave (client ports, I-cache fill, RAM bus)
// -----------------------------------------------------------------------------
module mem_ctrl #(
  parameter int         ADDR_W    = 32,
  parameter int         DATA_W    = 32,
  parameter logic [1:0] STAT_IDLE = 2'b00,
  parameter logic [1:0] STAT_BUSY = 2'b01,
  parameter logic [1:0] STAT_DONE = 2'b10
) (
  input  logic       clk,
  input  logic       rst,
  mem_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RD_TAIL, S_WR, S_RESP} state_t;
  typedef enum logic {CL_MEM, CL_IF} client_t;

  state_t            state_q, state_d;
  client_t           client_q, client_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        last_q, last_d;      // index of the final byte (length-1)
  logic [1:0]        cnt_q, cnt_d;        // index of the byte whose address is on ram_a
  logic              cancel_q, cancel_d;
  logic [DATA_W-1:0] shift_q, shift_d;    // read bytes enter at the top, shift down
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic [ADDR_W-1:0] icache_addr_q, icache_addr_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic              ram_wr_q, ram_wr_d;
  logic [7:0]        ram_dout_q, ram_dout_d;

  logic [1:0]        cnt_inc;
  logic [1:0]        req_last;
  logic [DATA_W-1:0] shift_in;
  logic [DATA_W-1:0] rd_word;
  logic [1:0]        act_status;

  // Unsupported lengths fall back to a full word.
  always_comb begin
    case (bus.mem_len)
      3'd1:    req_last = 2'd0;
      3'd2:    req_last = 2'd1;
      default: req_last = 2'd3;
    endcase
  end

  assign cnt_inc  = cnt_q + 2'd1;
  assign shift_in = {bus.ram_din, shift_q[DATA_W-1:8]};
  // After L captures the bytes occupy the top L lanes; shifting them down by
  // (4-L) bytes aligns byte 0 to bit 0 and zero-fills the upper lanes.
  assign rd_word  = shift_in >> {2'd3 - last_q, 3'b000};

  // NOTE: every signal gets a default before the case, so no path can leave a
  // value unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    client_d      = client_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    cancel_d      = cancel_q;
    shift_d       = shift_q;
    if_data_d     = if_data_q;
    mem_rdata_d   = mem_rdata_q;
    icache_addr_d = icache_addr_q;
    ram_a_d       = ram_a_q;
    ram_wr_d      = 1'b0;
    ram_dout_d    = ram_dout_q;

    case (state_q)
      S_IDLE: begin
        if (bus.mem_req) begin
          client_d = CL_MEM;
          addr_d   = bus.mem_addr;
          wdata_d  = bus.mem_wdata;
          last_d   = req_last;
          cnt_d    = 2'd0;
          cancel_d = 1'b0;
          ram_a_d  = bus.mem_addr;
          if (bus.mem_we) begin
            state_d    = S_WR;
            ram_wr_d   = 1'b1;
            ram_dout_d = bus.mem_wdata[7:0];
          end else begin
            state_d = S_RD;
          end
        end else if (bus.if_rw && !bus.if_cancel) begin
          client_d = CL_IF;
          addr_d   = bus.if_addr;
          last_d   = 2'd3;
          cnt_d    = 2'd0;
          cancel_d = 1'b0;
          ram_a_d  = bus.if_addr;
          state_d  = S_RD;
        end
      end

      S_RD: begin
        // Data for the previous address is on ram_din now.
        if (cnt_q != 2'd0) shift_d = shift_in;
        if (client_q == CL_IF && bus.if_cancel) cancel_d = 1'b1;
        if (cnt_q == last_q) begin
          state_d = S_RD_TAIL;
        end else begin
          cnt_d   = cnt_inc;
          ram_a_d = addr_q + ADDR_W'(cnt_inc);
        end
      end

      S_RD_TAIL: begin
        shift_d = shift_in;
        if (client_q == CL_MEM) begin
          mem_rdata_d = rd_word;
          state_d     = S_RESP;
        end else if (cancel_q || bus.if_cancel) begin
          // Bus sequence is finished; the fetch result is simply discarded.
          state_d = S_IDLE;
        end else begin
          if_data_d     = rd_word;
          icache_addr_d = addr_q;
          state_d       = S_RESP;
        end
      end

      S_WR: begin
        if (cnt_q == last_q) begin
          state_d = S_RESP;
        end else begin
          cnt_d      = cnt_inc;
          ram_a_d    = addr_q + ADDR_W'(cnt_inc);
          ram_wr_d   = 1'b1;
          ram_dout_d = wdata_q[{cnt_inc, 3'b000} +: 8];
        end
      end

      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its _d input regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      client_q      <= CL_MEM;
      addr_q        <= '0;
      wdata_q       <= '0;
      last_q        <= '0;
      cnt_q         <= '0;
      cancel_q      <= 1'b0;
      shift_q       <= '0;
      if_data_q     <= '0;
      mem_rdata_q   <= '0;
      icache_addr_q <= '0;
      ram_a_q       <= '0;
      ram_wr_q      <= 1'b0;
      ram_dout_q    <= '0;
    end else begin
      state_q       <= state_d;
      client_q      <= client_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      cancel_q      <= cancel_d;
      shift_q       <= shift_d;
      if_data_q     <= if_data_d;
      mem_rdata_q   <= mem_rdata_d;
      icache_addr_q <= icache_addr_d;
      ram_a_q       <= ram_a_d;
      ram_wr_q      <= ram_wr_d;
      ram_dout_q    <= ram_dout_d;
    end
  end

  always_comb begin
    act_status = STAT_IDLE;
    case (state_q)
      S_RD, S_RD_TAIL, S_WR: act_status = STAT_BUSY;
      S_RESP:                act_status = STAT_DONE;
      default:               act_status = STAT_IDLE;
    endcase
  end

  assign bus.if_status   = (client_q == CL_IF)  ? act_status : STAT_IDLE;
  assign bus.mem_status  = (client_q == CL_MEM) ? act_status : STAT_IDLE;
  assign bus.if_data     = if_data_q;
  assign bus.mem_rdata   = mem_rdata_q;
  assign bus.icache_we   = (state_q == S_RESP) && (client_q == CL_IF);
  assign bus.icache_addr = icache_addr_q;
  assign bus.icache_data = if_data_q;
  assign bus.ram_a       = ram_a_q;
  assign bus.ram_wr      = ram_wr_q;
  assign bus.ram_dout    = ram_dout_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl
// Directed bench for mem_ctrl. A byte RAM model answers one cycle after the
// address; expected DONE results are queued when a request is issued and
// compared by a monitor when the DUT reports DONE. Cycle 0 is the cycle in
// which a request is presented; inputs change 1 time unit after the rising
// edge and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_ctrl_if bus ();
  mem_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  // RAM model: 4 KiB window addressed by the low 12 address bits.
  logic [7:0] ram [0:4095];
  always @(posedge clk) begin
    if (bus.ram_wr) ram[bus.ram_a[11:0]] <= bus.ram_dout;
    bus.ram_din <= ram[bus.ram_a[11:0]];
  end

  typedef struct { logic [31:0] addr; logic [31:0] data; } if_exp_t;
  typedef struct { logic chk; logic [31:0] data; } mem_exp_t;
  if_exp_t  if_q[$];
  mem_exp_t mem_q[$];

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Expected status for cycle c: BUSY in [b0,b1], DONE at d, IDLE otherwise.
  function automatic logic [31:0] st(input int c, input int b0, input int b1, input int d);
    if (c == d)             return {30'd0, ST_DONE};
    if (c >= b0 && c <= b1) return {30'd0, ST_BUSY};
    return {30'd0, ST_IDLE};
  endfunction

  // Scoreboard side: every DONE must match the oldest queued expectation.
  always @(negedge clk) begin
    if_exp_t  ie;
    mem_exp_t me;
    if (bus.if_status == ST_DONE) begin
      check("if_done_expected", 32'(if_q.size() != 0), 32'd1);
      if (if_q.size() != 0) begin
        ie = if_q.pop_front();
        check("if_data", bus.if_data, ie.data);
        check("icache_data", bus.icache_data, ie.data);
        check("icache_addr", bus.icache_addr, ie.addr);
      end
    end
    if (bus.mem_status == ST_DONE) begin
      check("mem_done_expected", 32'(mem_q.size() != 0), 32'd1);
      if (mem_q.size() != 0) begin
        me = mem_q.pop_front();
        if (me.chk) check("mem_rdata", bus.mem_rdata, me.data);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp);
    if_q.push_back('{addr: a, data: exp});
    bus.if_rw   = 1'b1;
    bus.if_addr = a;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      check("fetch_if_status", 32'(bus.if_status), st(c, 1, 5, 6));
      check("fetch_icache_we", 32'(bus.icache_we), 32'(c == 6));
      check("fetch_ram_wr", 32'(bus.ram_wr), 32'd0);
      if (c >= 1 && c <= 4) check("fetch_ram_a", bus.ram_a, a + 32'(c - 1));
      next_cycle();
      if (c == 0) begin
        bus.if_rw   = 1'b0;
        bus.if_addr = 32'hDEAD_BEEF;
      end
    end
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] len, input int eff,
                         input logic [31:0] exp);
    mem_q.push_back('{chk: 1'b1, data: exp});
    bus.mem_req  = 1'b1;
    bus.mem_we   = 1'b0;
    bus.mem_len  = len;
    bus.mem_addr = a;
    for (int c = 0; c <= eff + 3; c++) begin
      @(negedge clk);
      check("load_mem_status", 32'(bus.mem_status), st(c, 1, eff + 1, eff + 2));
      check("load_ram_wr", 32'(bus.ram_wr), 32'd0);
      if (c >= 1 && c <= eff) check("load_ram_a", bus.ram_a, a + 32'(c - 1));
      next_cycle();
      if (c == 0) begin
        bus.mem_req  = 1'b0;
        bus.mem_len  = 3'd1;
        bus.mem_addr = 32'h5555_5555;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    {ram[12'h100], ram[12'h101], ram[12'h102], ram[12'h103]} = {8'h13, 8'h05, 8'h00, 8'h00};
    {ram[12'h104], ram[12'h105], ram[12'h106], ram[12'h107]} = {8'h93, 8'h00, 8'h10, 8'h00};
    {ram[12'h040], ram[12'h041], ram[12'h042], ram[12'h043]} = {8'h11, 8'h22, 8'h33, 8'h44};
    {ram[12'hFFE], ram[12'hFFF], ram[12'h000], ram[12'h001]} = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
    bus.ram_din   = 8'h00;
    rst           = 1'b1;
    bus.if_rw     = 1'b0;
    bus.if_addr   = '0;
    bus.if_cancel = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_len   = 3'd4;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;

    // Reset state.
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_if_status", 32'(bus.if_status), 32'(ST_IDLE));
    check("rst_mem_status", 32'(bus.mem_status), 32'(ST_IDLE));
    check("rst_if_data", bus.if_data, 32'd0);
    check("rst_mem_rdata", bus.mem_rdata, 32'd0);
    check("rst_icache_we", 32'(bus.icache_we), 32'd0);
    check("rst_icache_addr", bus.icache_addr, 32'd0);
    check("rst_icache_data", bus.icache_data, 32'd0);
    check("rst_ram_a", bus.ram_a, 32'd0);
    check("rst_ram_wr", 32'(bus.ram_wr), 32'd0);
    check("rst_ram_dout", 32'(bus.ram_dout), 32'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Basic fetch.
    do_fetch(32'h0000_0100, 32'h0000_0513);

    // Store half-word; operands change after acceptance and must be ignored.
    mem_q.push_back('{chk: 1'b0, data: 32'd0});
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b1;
    bus.mem_len   = 3'd2;
    bus.mem_addr  = 32'h0000_0020;
    bus.mem_wdata = 32'hABCD_1234;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      check("store_mem_status", 32'(bus.mem_status), st(c, 1, 2, 3));
      check("store_ram_wr", 32'(bus.ram_wr), 32'(c == 1 || c == 2));
      if (c == 1) begin
        check("store_ram_a0", bus.ram_a, 32'h0000_0020);
        check("store_ram_dout0", 32'(bus.ram_dout), 32'h34);
      end
      if (c == 2) begin
        check("store_ram_a1", bus.ram_a, 32'h0000_0021);
        check("store_ram_dout1", 32'(bus.ram_dout), 32'h12);
      end
      next_cycle();
      if (c == 0) begin
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 32'h0000_0999;
        bus.mem_wdata = 32'hFFFF_FFFF;
      end
    end

    // Loads: half-word, byte, and an unsupported length treated as a word.
    do_load(32'h0000_0020, 3'd2, 2, 32'h0000_1234);
    do_load(32'h0000_0020, 3'd1, 1, 32'h0000_0034);
    do_load(32'h0000_0040, 3'd3, 4, 32'h4433_2211);

    // Contention: MEM word load wins, IF fetch follows.
    mem_q.push_back('{chk: 1'b1, data: 32'h4433_2211});
    if_q.push_back('{addr: 32'h0000_0104, data: 32'h0010_0093});
    bus.mem_req  = 1'b1;
    bus.mem_we   = 1'b0;
    bus.mem_len  = 3'd4;
    bus.mem_addr = 32'h0000_0040;
    bus.if_rw    = 1'b1;
    bus.if_addr  = 32'h0000_0104;
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      check("cont_mem_status", 32'(bus.mem_status), st(c, 1, 5, 6));
      check("cont_if_status", 32'(bus.if_status), st(c, 8, 12, 13));
      check("cont_icache_we", 32'(bus.icache_we), 32'(c == 13));
      next_cycle();
      if (c == 0) bus.mem_req = 1'b0;
      if (c == 7) bus.if_rw = 1'b0;
    end

    // Cancel an in-flight fetch: bus completes, no DONE, no I-cache fill.
    bus.if_rw   = 1'b1;
    bus.if_addr = 32'h0000_0100;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      check("cancel_if_status", 32'(bus.if_status), st(c, 1, 5, -1));
      check("cancel_icache_we", 32'(bus.icache_we), 32'd0);
      if (c >= 1 && c <= 4) check("cancel_ram_a", bus.ram_a, 32'h0000_0100 + 32'(c - 1));
      if (c == 5) check("cancel_ram_a_held", bus.ram_a, 32'h0000_0103);
      next_cycle();
      if (c == 0) bus.if_rw = 1'b0;
      if (c == 2) bus.if_cancel = 1'b1;
      if (c == 3) bus.if_cancel = 1'b0;
    end

    // Reset in cycle 2 of a word store: access dropped, no DONE.
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b1;
    bus.mem_len   = 3'd4;
    bus.mem_addr  = 32'h0000_0200;
    bus.mem_wdata = 32'hDEAD_BEEF;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      check("rstwr_ram_wr", 32'(bus.ram_wr), 32'(c == 1 || c == 2));
      check("rstwr_mem_status", 32'(bus.mem_status), st(c, 1, 2, -1));
      check("rstwr_if_status", 32'(bus.if_status), 32'(ST_IDLE));
      next_cycle();
      if (c == 0) begin
        bus.mem_req = 1'b0;
        bus.mem_we  = 1'b0;
      end
      if (c == 1) rst = 1'b1;
      if (c == 2) rst = 1'b0;
    end
    do_fetch(32'h0000_0100, 32'h0000_0513);

    // Address wrap past 0xFFFFFFFF.
    do_load(32'hFFFF_FFFE, 3'd4, 4, 32'hD4C3_B2A1);

    check("if_queue_drained", 32'(if_q.size()), 32'd0);
    check("mem_queue_drained", 32'(mem_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
